// File: rtl/mips_mem_bridge_if.sv
// Memory-side bus of the MIPS multicycle memory bridge.
// Master drives request/address/data; slave answers with ack and read data.
interface mips_mem_bridge_if;
    localparam int unsigned XLEN = 32;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mips_mem_bridge.sv
// Bridges the multicycle MIPS control FSM to a single-outstanding memory bus.
// Optional: define MIPS_MEM_TIMEOUT_EN to abort a BUS access after 255 ack-less cycles.
module mips_mem_bridge (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc,
    input  logic [31:0]        alu_out,
    input  logic [31:0]        wdata_in,
    input  logic               ir_write,
    input  logic               i_or_d,
    input  logic               mem_write,
    output logic [31:0]        instr,
    output logic [31:0]        mdr,
    output logic               stall,
    output logic               err,
    mips_mem_bridge_if.master  mem
);
    localparam int unsigned XLEN = 32;

    typedef enum logic {S_IDLE, S_BUS} state_e;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_e;

    state_e          r_state;
    state_e          w_next_state;
    kind_e           r_kind;
    kind_e           w_kind;
    logic            w_store;
    logic            w_fetch;
    logic            w_load;
    logic            w_any;
    logic            w_latch;
    logic            w_done;
    logic [XLEN-1:0] w_addr_raw;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_mdr;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic            r_mem_req;
    logic            r_mem_we;
    logic            r_err;

`ifdef MIPS_MEM_TIMEOUT_EN
    localparam int unsigned TMO_W = 8;
    // Counter holds the number of ack-less BUS cycles already elapsed.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(254);
    logic [TMO_W-1:0] r_tmo;
    logic             w_abort;
`endif

    // Request decode with store > fetch > load priority.
    always_comb begin
        w_store = mem_write;
        w_fetch = ir_write;
        w_load  = i_or_d & ~mem_write;
        w_any   = w_store | w_fetch | w_load;
        if (w_store) begin
            w_kind = K_STORE;
        end else if (w_fetch) begin
            w_kind = K_FETCH;
        end else begin
            w_kind = K_LOAD;
        end
        w_addr_raw = (w_kind == K_FETCH) ? pc : alu_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_done       = 1'b0;
`ifdef MIPS_MEM_TIMEOUT_EN
        w_abort      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_latch      = 1'b1;
                    w_next_state = S_BUS;
                end
            end
            S_BUS: begin
                if (mem.mem_ack) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
`ifdef MIPS_MEM_TIMEOUT_EN
                else if (r_tmo == TMO_LAST) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end
`endif
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Holds the control FSM from the request cycle until the access retires.
    assign stall = (r_state == S_BUS) | ((r_state == S_IDLE) & w_any);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kind      <= K_FETCH;
            r_instr     <= '0;
            r_mdr       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_latch) begin
                r_kind     <= w_kind;
                r_mem_addr <= {w_addr_raw[XLEN-1:2], 2'b00};
                r_mem_req  <= 1'b1;
                r_mem_we   <= (w_kind == K_STORE);
                if (w_kind == K_STORE) begin
                    r_mem_wdata <= wdata_in;
                end
                if (w_addr_raw[1:0] != 2'b00) begin
                    r_err <= 1'b1;
                end
            end
            if (w_done) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (r_kind == K_FETCH) begin
                    r_instr <= mem.mem_rdata;
                end
                if (r_kind == K_LOAD) begin
                    r_mdr <= mem.mem_rdata;
                end
            end
`ifdef MIPS_MEM_TIMEOUT_EN
            if (w_abort) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                r_err     <= 1'b1;
            end
`endif
        end
    end

`ifdef MIPS_MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (w_latch) begin
            r_tmo <= '0;
        end else if ((r_state == S_BUS) && !mem.mem_ack) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end
`endif

    assign instr         = r_instr;
    assign mdr           = r_mdr;
    assign err           = r_err;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mips_mem_bridge.sv
// Self-checking bench for mips_mem_bridge: directed table, corner sequences,
// and randomized accesses against a transaction-level model.
module tb_mips_mem_bridge;
    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] wdata_in;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_write;
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        stall;
    logic        err;

    mips_mem_bridge_if bus();

    mips_mem_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata_in  (wdata_in),
        .ir_write  (ir_write),
        .i_or_d    (i_or_d),
        .mem_write (mem_write),
        .instr     (instr),
        .mdr       (mdr),
        .stall     (stall),
        .err       (err),
        .mem       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        irw;
        logic        iod;
        logic        mw;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          n_wait;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_mdr;
        logic        exp_err;
    } vec_t;

    vec_t vec [8];

    // Transaction-level model state
    logic [31:0] m_instr;
    logic [31:0] m_mdr;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic clear_inputs();
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_write     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = $urandom;
        step();
        rst = 1'b0;
        clear_inputs();
        #1;
    endtask

    // One access from IDLE: request cycle, n_wait ack-less BUS cycles, ack cycle.
    task automatic access(input logic irw, input logic iod, input logic mw,
                          input logic [31:0] a_pc, input logic [31:0] a_alu,
                          input logic [31:0] a_wd, input int n_wait,
                          input logic [31:0] rdata, input logic exp_we,
                          input logic [31:0] exp_addr, output int sc);
        sc            = 0;
        ir_write      = irw;
        i_or_d        = iod;
        mem_write     = mw;
        pc            = a_pc;
        alu_out       = a_alu;
        wdata_in      = a_wd;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        #1;
        if (stall) sc++;
        chk("idle_req_low", 32'(bus.mem_req), 32'd0);
        step();
        ir_write  = 1'($urandom_range(0, 1));
        i_or_d    = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
        pc        = $urandom;
        alu_out   = $urandom;
        wdata_in  = $urandom;
        for (int k = 0; k <= n_wait; k++) begin
            bus.mem_ack   = (k == n_wait);
            bus.mem_rdata = (k == n_wait) ? rdata : $urandom;
            #1;
            if (stall) sc++;
            chk("bus_req", 32'(bus.mem_req), 32'd1);
            chk("bus_we", 32'(bus.mem_we), 32'(exp_we));
            chk("bus_addr", bus.mem_addr, exp_addr);
            if (exp_we) chk("bus_wdata", bus.mem_wdata, a_wd);
            step();
        end
        clear_inputs();
        #1;
        if (stall) sc++;
        chk("done_req", 32'(bus.mem_req), 32'd0);
        chk("done_we", 32'(bus.mem_we), 32'd0);
    endtask

    // IDLE cycle with a stray ack that must be ignored.
    task automatic idle_cycle(input logic [31:0] e_instr, input logic [31:0] e_mdr);
        clear_inputs();
        pc            = $urandom;
        alu_out       = $urandom;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = $urandom;
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        step();
        bus.mem_ack = 1'b0;
        chk("idle_instr", instr, e_instr);
        chk("idle_mdr", mdr, e_mdr);
        chk("idle_req", 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        int          sc;
        logic        r_irw, r_iod, r_mw;
        logic [31:0] r_pc, r_alu, r_wd, r_rd, raw;
        int          r_wait;

        vec[0] = '{1'b1, 1'b0, 1'b0, 32'h40,   32'h0,   32'h0,        32'h11112222, 0, 1'b0, 32'h40,   32'h11112222, 32'h0,        1'b0};
        vec[1] = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h84,  32'h0,        32'h33334444, 1, 1'b0, 32'h84,   32'h11112222, 32'h33334444, 1'b0};
        vec[2] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h200, 32'hCAFEF00D, 32'h55555555, 2, 1'b1, 32'h200,  32'h11112222, 32'h33334444, 1'b0};
        vec[3] = '{1'b1, 1'b1, 1'b0, 32'h1000, 32'h2000,32'h0,        32'h66667777, 0, 1'b0, 32'h1000, 32'h66667777, 32'h33334444, 1'b0};
        vec[4] = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h300, 32'h0,        32'h89ABCDEF, 3, 1'b0, 32'h300,  32'h66667777, 32'h89ABCDEF, 1'b0};
        vec[5] = '{1'b1, 1'b1, 1'b1, 32'h500,  32'h400, 32'h01020304, 32'h99999999, 0, 1'b1, 32'h400,  32'h66667777, 32'h89ABCDEF, 1'b0};
        vec[6] = '{1'b1, 1'b0, 1'b0, 32'h13,   32'h0,   32'h0,        32'h0BADF00D, 1, 1'b0, 32'h10,   32'h0BADF00D, 32'h89ABCDEF, 1'b1};
        vec[7] = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h10,  32'h0,        32'h00000077, 0, 1'b0, 32'h10,   32'h0BADF00D, 32'h00000077, 1'b1};

        pc = '0; alu_out = '0; wdata_in = '0;
        clear_inputs();
        rst = 1'b1;
        step();
        do_reset();

        // Reset state
        chk("rst_instr", instr, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // Fetch, ack in third BUS cycle
        access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 2, 32'h8C220004, 1'b0, 32'h10, sc);
        chk("fetch_instr", instr, 32'h8C220004);
        chk("fetch_stall_cycles", 32'(sc), 32'd4);
        chk("fetch_mdr", mdr, 32'h0);

        // Store with immediate ack; i_or_d also high
        access(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 0, 32'h12345678, 1'b1, 32'h100, sc);
        chk("store_mdr", mdr, 32'h0);
        chk("store_stall_cycles", 32'(sc), 32'd2);
        chk("store_err", 32'(err), 32'd0);

        // Store beats fetch; misaligned address sets sticky err
        access(1'b1, 1'b0, 1'b1, 32'h10, 32'h102, 32'h5A5A5A5A, 1, 32'hFFFFFFFF, 1'b1, 32'h100, sc);
        chk("prio_err", 32'(err), 32'd1);
        chk("prio_instr", instr, 32'h8C220004);
        idle_cycle(32'h8C220004, 32'h0);
        access(1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, 0, 32'hAAAA5555, 1'b0, 32'h44, sc);
        chk("sticky_err", 32'(err), 32'd1);
        chk("load_mdr", mdr, 32'hAAAA5555);

        // Reset during BUS with simultaneous ack
        i_or_d  = 1'b1;
        alu_out = 32'h20;
        step();
        i_or_d = 1'b0;
        chk("midrst_req", 32'(bus.mem_req), 32'd1);
        chk("midrst_addr", bus.mem_addr, 32'h20);
        rst           = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234;
        step();
        rst = 1'b0;
        clear_inputs();
        #1;
        chk("midrst_mdr", mdr, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_req_after", 32'(bus.mem_req), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);

        // Table-driven accesses from the fresh reset state
        for (int i = 0; i < 8; i++) begin
            access(vec[i].irw, vec[i].iod, vec[i].mw, vec[i].pc, vec[i].alu, vec[i].wd,
                   vec[i].n_wait, vec[i].rdata, vec[i].exp_we, vec[i].exp_addr, sc);
            chk($sformatf("vec%0d_instr", i), instr, vec[i].exp_instr);
            chk($sformatf("vec%0d_mdr", i), mdr, vec[i].exp_mdr);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vec[i].exp_err));
            chk($sformatf("vec%0d_stall", i), 32'(sc), 32'(vec[i].n_wait + 2));
        end

        // Randomized accesses against the model
        do_reset();
        m_instr = '0;
        m_mdr   = '0;
        m_err   = 1'b0;
        for (int it = 0; it < 200; it++) begin
            r_irw  = 1'($urandom_range(0, 1));
            r_iod  = 1'($urandom_range(0, 1));
            r_mw   = ($urandom_range(0, 3) == 0);
            r_pc   = rand_addr();
            r_alu  = rand_addr();
            r_wd   = $urandom;
            r_rd   = $urandom;
            r_wait = $urandom_range(0, 3);
            if (!(r_irw || r_iod || r_mw)) begin
                idle_cycle(m_instr, m_mdr);
            end else begin
                raw = (!r_mw && r_irw) ? r_pc : r_alu;
                if (raw % 4 != 0) m_err = 1'b1;
                access(r_irw, r_iod, r_mw, r_pc, r_alu, r_wd, r_wait, r_rd,
                       r_mw, raw & 32'hFFFF_FFFC, sc);
                if (r_mw) begin
                end else if (r_irw) begin
                    m_instr = r_rd;
                end else begin
                    m_mdr = r_rd;
                end
                chk("rnd_instr", instr, m_instr);
                chk("rnd_mdr", mdr, m_mdr);
                chk("rnd_err", 32'(err), 32'(m_err));
                chk("rnd_stall", 32'(sc), 32'(r_wait + 2));
            end
        end

        // Load that never sees an ack
        do_reset();
        access(1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 0, 32'hFEEDFACE, 1'b0, 32'h80, sc);
        i_or_d  = 1'b1;
        alu_out = 32'h20;
        step();
        i_or_d = 1'b0;
`ifdef MIPS_MEM_TIMEOUT_EN
        for (int c = 0; c < 254; c++) step();
        chk("tmo_still_bus", 32'(bus.mem_req), 32'd1);
        chk("tmo_err_before", 32'(err), 32'd0);
        step();
        chk("tmo_req", 32'(bus.mem_req), 32'd0);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_mdr", mdr, 32'hFEEDFACE);
        chk("tmo_stall", 32'(stall), 32'd0);
`else
        for (int c = 0; c < 1000; c++) step();
        chk("nowait_req", 32'(bus.mem_req), 32'd1);
        chk("nowait_stall", 32'(stall), 32'd1);
        chk("nowait_mdr", mdr, 32'hFEEDFACE);
`endif
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_mem_bridge.md
MIPS_MEM_BRIDGE -- requirements
Module: mips_mem_bridge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pc  input  32  fetch address.
REQ-005 alu_out  input  32  load/store address.
REQ-006 wdata_in  input  32  store data (B register).
REQ-007 ir_write  input  1  fetch request from control.
REQ-008 i_or_d  input  1  data access select from control.
REQ-009 mem_write  input  1  store request from control.
REQ-010 instr  output  32  instruction register.
REQ-011 mdr  output  32  memory data register.
REQ-012 stall  output  1  holds the control FSM while an access is in progress.
REQ-013 mem_req  output  1  bus request.
REQ-014 mem_we  output  1  bus write enable.
REQ-015 mem_addr  output  32  bus address, word-aligned.
REQ-016 mem_wdata  output  32  bus write data.
REQ-017 mem_ack  input  1  bus completion.
REQ-018 mem_rdata  input  32  bus read data, valid with mem_ack.
REQ-019 err  output  1  sticky error flag.

Function
REQ-020 Request kinds are decoded only in IDLE:
- store = mem_write
- fetch = ir_write
- load = i_or_d & ~mem_write
REQ-021 When more than one request kind is asserted in the same cycle, the priority SHALL be store > fetch > load; lower-priority requests SHALL be dropped.
REQ-022 States SHALL be IDLE and BUS only.
REQ-023 IDLE with a request SHALL latch kind, address and store data, then go to BUS on the next edge:
- fetch uses pc; load and store use alu_out
- latched address bits [1:0] are forced to 00
REQ-024 In BUS:
- mem_req = 1, mem_we = 1 for a store only
- mem_addr and mem_wdata SHALL hold the latched values, stable until ack
REQ-025 BUS with mem_ack = 1 SHALL return to IDLE on that edge:
- fetch: instr <= mem_rdata
- load: mdr <= mem_rdata
- store: no register update
REQ-026 mem_ack SHALL be ignored in IDLE.
REQ-027 stall SHALL be combinational: 1 when in BUS, or when in IDLE with any request asserted; 0 otherwise.
REQ-028 Minimum access latency SHALL be 2 cycles: request cycle, then BUS with ack in the first BUS cycle; instr/mdr are updated at the end of the ack cycle.
REQ-029 If the latched address had bits [1:0] != 00, err SHALL be set at the latch edge and the access SHALL still proceed at the aligned address.
REQ-030 err SHALL be sticky until reset.
REQ-031 instr and mdr SHALL hold their values between updates.
REQ-032 mem_req and mem_we SHALL be 0 in IDLE.

Reset
REQ-033 rst = 1 at an edge SHALL force:
- state IDLE
- instr = 0, mdr = 0
- mem_req = 0, mem_we = 0
- mem_addr = 0, mem_wdata = 0
- err = 0
REQ-034 Reset during BUS SHALL abort the access; a mem_ack in the same cycle SHALL be discarded.
REQ-035 stall SHALL read 0 in the cycle after reset while no request is asserted.

Configuration
REQ-036 MIPS_MEM_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to BUS and increment each BUS cycle without ack; at 255 with no ack, the block SHALL:
- return to IDLE
- set err
- leave instr/mdr unchanged
REQ-037 MIPS_MEM_TIMEOUT_EN undefined: the counter SHALL not exist and BUS SHALL wait indefinitely for mem_ack.

Verification
REQ-038 Fetch: pc = 0x00000010, ir_write = 1, ack with rdata 0x8C220004 after 3 BUS cycles -> mem_addr = 0x10, mem_we = 0, instr = 0x8C220004, stall high for 4 cycles.
REQ-039 Store: alu_out = 0x00000100, wdata_in = 0xDEADBEEF, mem_write = 1, i_or_d = 1, immediate ack -> one BUS cycle with mem_we = 1, mem_addr = 0x100, mem_wdata = 0xDEADBEEF; mdr unchanged.
REQ-040 Priority and misalignment: ir_write = 1 and mem_write = 1 together with alu_out = 0x00000102 -> store at 0x100 issued, fetch dropped, err = 1 and remains 1.
REQ-041 Reset mid-access: load at 0x20 in BUS, rst asserted with mem_ack = 1, rdata 0x1234 -> mdr = 0, state IDLE, mem_req = 0 next cycle.
REQ-042 Timeout (MIPS_MEM_TIMEOUT_EN defined): load with no ack -> return to IDLE after 255 BUS cycles, err = 1, mdr unchanged.
REQ-043 Timeout (MIPS_MEM_TIMEOUT_EN undefined): load with no ack -> still in BUS after 1000 cycles.
